// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module : memory_access
// Desc   : Load/store pipeline stage. Issues at most one aligned data-memory
//          access at a time and returns a single writeback pulse carrying the
//          load result, store completion, misalignment or bus error.
// Rev    : 1.0
// ============================================================================
module memory_access #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_width,
    input  logic [4:0]  rd_in,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [1:0] c_op_load  = 2'b01;
    localparam logic [1:0] c_op_store = 2'b10;
    localparam logic [9:0] c_tmo_last = 10'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_tcnt;
    logic [2:0]  r_width;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic        r_is_load;
    logic        r_req_valid;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_misaligned;
    logic        r_bus_err;

    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_complete;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [31:0] w_load_data;

    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_is_load  = (mem_op == c_op_load);
    assign w_is_store = (mem_op == c_op_store);
    // Width low bits 00 = byte (B/BU), 01 = half (H/HU); every other code is a word.
    assign w_is_byte  = (mem_width[1:0] == 2'b00);
    assign w_is_half  = (mem_width[1:0] == 2'b01);
    assign w_misaligned = w_is_half ? alu_out[0] :
                          (w_is_byte ? 1'b0 : (alu_out[1:0] != 2'b00));

    // A response in the handshake cycle completes straight from REQ.
    assign w_complete = dmem_resp_valid &&
                        ((r_state == ST_WAIT) || (r_state == ST_REQ && dmem_req_ready));

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = rs2_data;
        if (w_is_byte) begin
            w_wstrb = 4'b0001 << alu_out[1:0];
            w_wdata = {4{rs2_data[7:0]}};
        end else if (w_is_half) begin
            w_wstrb = alu_out[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{rs2_data[15:0]}};
        end
    end

    assign w_rbyte = dmem_rdata[{r_off, 3'b000} +: 8];
    assign w_rhalf = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load_data = dmem_rdata;
        if (r_width[1:0] == 2'b00) begin
            w_load_data = {{24{~r_width[2] & w_rbyte[7]}}, w_rbyte};
        end else if (r_width[1:0] == 2'b01) begin
            w_load_data = {{16{~r_width[2] & w_rhalf[15]}}, w_rhalf};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            r_width      <= '0;
            r_off        <= '0;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
            r_req_valid  <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            if (w_complete) begin
                r_state     <= ST_IDLE;
                r_req_valid <= 1'b0;
                r_wb_valid  <= 1'b1;
                r_wb_we     <= r_is_load;
                r_wb_rd     <= r_rd;
                r_wb_data   <= r_is_load ? w_load_data : 32'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_wb_rd <= rd_in;
                            if (!w_is_load && !w_is_store) begin
                                r_wb_valid <= 1'b1;
                                r_wb_we    <= 1'b1;
                                r_wb_data  <= alu_out;
                            end else if (w_misaligned) begin
                                r_wb_valid   <= 1'b1;
                                r_wb_we      <= 1'b0;
                                r_wb_data    <= 32'd0;
                                r_misaligned <= 1'b1;
                            end else begin
                                r_state     <= ST_REQ;
                                r_req_valid <= 1'b1;
                                r_addr      <= {alu_out[31:2], 2'b00};
                                r_we        <= w_is_store;
                                r_wstrb     <= w_is_store ? w_wstrb : 4'b0000;
                                r_wdata     <= w_is_store ? w_wdata : 32'd0;
                                r_width     <= mem_width;
                                r_off       <= alu_out[1:0];
                                r_rd        <= rd_in;
                                r_is_load   <= w_is_load;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (dmem_req_ready) begin
                            r_state     <= ST_WAIT;
                            r_req_valid <= 1'b0;
                            r_tcnt      <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (r_tcnt == c_tmo_last) begin
                            r_state    <= ST_IDLE;
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= 1'b0;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= 32'd0;
                            r_bus_err  <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 10'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready       = (r_state == ST_IDLE);
    assign dmem_req_valid = r_req_valid;
    assign dmem_addr      = r_addr;
    assign dmem_we        = r_we;
    assign dmem_wstrb     = r_wstrb;
    assign dmem_wdata     = r_wdata;
    assign wb_valid       = r_wb_valid;
    assign wb_we          = r_wb_we;
    assign wb_rd          = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign misaligned     = r_misaligned;
    assign bus_err        = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module : tb_memory_access
// Desc   : Randomized scoreboard bench for memory_access with a byte-level
//          memory model and a separate randomly-stalling memory responder.
// Rev    : 1.0
// ============================================================================
module tb_memory_access;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [1:0]  mem_op;
    logic [2:0]  mem_width;
    logic [4:0]  rd_in;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_err;

    memory_access #(.RESP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .rs2_data(rs2_data), .mem_op(mem_op), .mem_width(mem_width),
        .rd_in(rd_in), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        berr;
        logic        cmp_rd;
        logic        cmp_data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          issued = 0;
    int          hs_cyc = 0;
    bit          drop_next = 1'b0;
    logic [7:0]  mbytes[64];
    logic [31:0] rwords[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per writeback pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_wb_valid", wb_valid, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("wb_we", wb_we, e.we);
                    chk("misaligned", misaligned, e.mis);
                    chk("bus_err", bus_err, e.berr);
                    if (e.cmp_rd) chk("wb_rd", wb_rd, e.rd);
                    if (e.cmp_data) chk("wb_data", wb_data, e.data);
                    if (e.berr) chk("timeout_latency", cyc - hs_cyc, TMO + 1);
                end
                done_cnt++;
            end else if (misaligned || bus_err) begin
                chk("stray_exception", {misaligned, bus_err}, 0);
            end
        end
    end

    // Responder: random grant stall, random response latency, optional drop.
    initial begin
        logic [31:0] a, wd, rdat;
        logic        we;
        logic [3:0]  st;
        int          lat;
        bit          drop;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_rdata      = '0;
        forever begin
            @(negedge clk);
            if (dmem_req_valid) begin
                a = dmem_addr; we = dmem_we; st = dmem_wstrb; wd = dmem_wdata;
                drop = drop_next;
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    chk("req_held_valid", dmem_req_valid, 1'b1);
                    chk("req_held_addr", dmem_addr, a);
                    chk("req_held_we_strb", {dmem_we, dmem_wstrb}, {we, st});
                    chk("req_held_wdata", dmem_wdata, wd);
                end
                dmem_req_ready = 1'b1;
                hs_cyc = cyc;
                if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (st[i]) rwords[a[5:2]][8*i +: 8] = wd[8*i +: 8];
                end
                rdat = rwords[a[5:2]];
                lat = drop ? -1 : int'($urandom_range(0, 3));
                if (lat == 0) begin
                    dmem_resp_valid = 1'b1;
                    dmem_rdata = rdat;
                end
                @(negedge clk);
                dmem_req_ready  = 1'b0;
                dmem_resp_valid = 1'b0;
                dmem_rdata      = $urandom;
                if (lat > 0) begin
                    repeat (lat - 1) @(negedge clk);
                    dmem_resp_valid = 1'b1;
                    dmem_rdata = rdat;
                    @(negedge clk);
                    dmem_resp_valid = 1'b0;
                    dmem_rdata = $urandom;
                end else if (drop) begin
                    repeat (TMO + 2) @(negedge clk);
                    dmem_resp_valid = 1'b1;
                    dmem_rdata = $urandom;
                    @(negedge clk);
                    dmem_resp_valid = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] w, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input bit drop);
        exp_t        e;
        int          size, off, ai, k;
        bit          mem, mis, sgn;
        logic [31:0] v;
        logic [3:0]  strb;
        wait_ready();
        mem  = (op == 2'b01) || (op == 2'b10);
        size = (w == 3'd0 || w == 3'd4) ? 1 : ((w == 3'd1 || w == 3'd5) ? 2 : 4);
        sgn  = (w == 3'd0 || w == 3'd1);
        off  = int'(addr[1:0]);
        ai   = int'(addr[5:0]);
        mis  = mem && (off % size != 0);
        e = '{we: 1'b0, rd: rd, data: 32'd0, mis: mis, berr: 1'b0, cmp_rd: 1'b0, cmp_data: 1'b0};
        if (!mem) begin
            e.we = 1'b1; e.data = addr; e.cmp_rd = 1'b1; e.cmp_data = 1'b1;
        end else if (!mis) begin
            if (op == 2'b10) begin
                for (int i = 0; i < size; i++) mbytes[ai + i] = data[8*i +: 8];
                e.cmp_data = !drop;
            end else if (!drop) begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (32'(mbytes[ai + i]) << (8 * i));
                if (sgn && size < 4 && v[8*size-1]) v = v - (32'd1 << (8 * size));
                e.we = 1'b1; e.data = v; e.cmp_rd = 1'b1; e.cmp_data = 1'b1;
            end
            e.berr = drop;
        end
        sbq.push_back(e);
        issued++;
        drop_next = mem && !mis && drop;
        in_valid = 1'b1; mem_op = op; mem_width = w; alu_out = addr; rs2_data = data; rd_in = rd;
        @(negedge clk);
        in_valid = 1'b0; mem_op = 2'($urandom); mem_width = 3'($urandom);
        alu_out = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
        if (!mem || mis) begin
            chk("no_dmem_req", dmem_req_valid, 1'b0);
        end else begin
            strb = 4'(((1 << size) - 1) << off);
            chk("req_valid", dmem_req_valid, 1'b1);
            chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("req_we", dmem_we, op == 2'b10);
            if (op == 2'b10) begin
                chk("req_wstrb", dmem_wstrb, strb);
                for (int i = 0; i < 4; i++)
                    if (strb[i]) chk("req_wdata_lane", dmem_wdata[8*i +: 8], data[8*(i-off) +: 8]);
            end
        end
        k = 0;
        while (done_cnt < issued && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < issued) chk("completion_timeout", done_cnt, issued);
        if (drop_next) repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [2:0] w;
        logic [2:0] st_codes[6];
        st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 16; i++) begin
            rwords[i] = $urandom;
            for (int j = 0; j < 4; j++) mbytes[4*i + j] = rwords[i][8*j +: 8];
        end
        rst = 1'b1; in_valid = 1'b0; alu_out = '0; rs2_data = '0;
        mem_op = '0; mem_width = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc", {misaligned, bus_err, dmem_we}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 3'd2, 32'h1234_5678, 32'd0, 5'd5, 1'b0);
        issue(2'b10, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd1, 1'b0);
        issue(2'b10, 3'd2, 32'h0000_0100, 32'h0080_0000, 5'd2, 1'b0);
        issue(2'b01, 3'd0, 32'h0000_0102, 32'd0, 5'd3, 1'b0);
        issue(2'b01, 3'd4, 32'h0000_0102, 32'd0, 5'd4, 1'b0);
        issue(2'b01, 3'd2, 32'h0000_0102, 32'd0, 5'd6, 1'b0);
        issue(2'b01, 3'd1, 32'h0000_0105, 32'd0, 5'd7, 1'b0);
        issue(2'b11, 3'd2, 32'hDEAD_BEEF, 32'd0, 5'd8, 1'b0);
        issue(2'b01, 3'd2, 32'h0000_0108, 32'd0, 5'd9, 1'b1);
        chk("after_timeout_in_ready", in_ready, 1'b1);
        issue(2'b10, 3'd1, 32'h0000_010E, 32'h0000_C3A5, 5'd10, 1'b1);

        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom);
            w  = (op == 2'b10) ? st_codes[$urandom_range(0, 5)] : 3'($urandom);
            issue(op, w, (op == 2'b00 || op == 2'b11) ? $urandom : 32'h100 + $urandom_range(0, 63),
                  $urandom, 5'($urandom), $urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while waiting for a response that never comes.
        wait_ready();
        drop_next = 1'b1;
        in_valid = 1'b1; mem_op = 2'b01; mem_width = 3'd2; alu_out = 32'h104; rd_in = 5'd12;
        @(negedge clk);
        in_valid = 1'b0; mem_op = 2'b00;
        for (int k = 0; k < 20 && dmem_req_valid; k++) @(negedge clk);
        chk("reached_wait", dmem_req_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_in_ready", in_ready, 1'b1);
        chk("rst_wait_wb_valid", wb_valid, 1'b0);
        chk("rst_wait_req_valid", dmem_req_valid, 1'b0);
        repeat (12) @(negedge clk);
        chk("late_resp_in_ready", in_ready, 1'b1);
        issue(2'b00, 3'd0, 32'hCAFE_F00D, 32'd0, 5'd31, 1'b0);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter RESP_TIMEOUT, default 255: number of WAIT cycles without a response before a bus error is declared; legal range 1..1023.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port in_valid  input  1  execute result valid.
REQ-005 Port in_ready  output  1  stage can accept a new operation.
REQ-006 Port alu_out  input  32  ALU result; memory address for loads/stores.
REQ-007 Port rs2_data  input  32  store data.
REQ-008 Port mem_op  input  2  operation: 00 NONE, 01 LOAD, 10 STORE, 11 treated as NONE.
REQ-009 Port mem_width  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-010 Port rd_in  input  5  destination register.
REQ-011 Port dmem_req_valid / dmem_req_ready  output / input  1 / 1  memory request handshake.
REQ-012 Port dmem_addr  output  32  word-aligned address {alu_out[31:2],2'b00}.
REQ-013 Port dmem_we / dmem_wstrb / dmem_wdata  output  1 / 4 / 32  write enable, byte strobes, lane-aligned write data.
REQ-014 Port dmem_resp_valid / dmem_rdata  input  1 / 32  response strobe and read word.
REQ-015 Port wb_valid / wb_we / wb_rd / wb_data  output  1 / 1 / 5 / 32  writeback pulse, register-write enable, destination, data.
REQ-016 Port misaligned / bus_err  output  1 / 1  single-cycle exception pulses, coincident with wb_valid.

Function
REQ-017 FSM states: IDLE, REQ, WAIT; in_ready=1 only in IDLE; an operation is accepted when in_valid && in_ready.
REQ-018 NONE accepted: next cycle wb_valid=1, wb_we=1, wb_data=alu_out, wb_rd=rd_in; FSM stays IDLE; latency 1 cycle.
REQ-019 Misaligned check at acceptance: H/HU with alu_out[0]=1, W with alu_out[1:0]!=0 -> no dmem request; next cycle wb_valid=1, wb_we=0, misaligned=1.
REQ-020 Aligned LOAD/STORE accepted: IDLE->REQ; address, we, wstrb, wdata, width, byte offset and rd are registered; dmem_req_valid=1 from the next cycle.
REQ-021 In REQ, dmem_req_valid and all dmem_* outputs SHALL stay stable until dmem_req_ready=1; on handshake REQ->WAIT, or directly to completion when dmem_resp_valid=1 in the same cycle.
REQ-022 In WAIT, dmem_req_valid=0; dmem_resp_valid=1 completes the operation; wb_valid pulses in the following cycle and FSM returns to IDLE in that same cycle.
REQ-023 Store strobes: B -> 4'b0001<<off, byte replicated x4; H -> 4'b0011<<(2*off[1]), halfword replicated x2; W -> 4'b1111, rs2_data; off=alu_out[1:0].
REQ-024 Load extraction from dmem_rdata at offset off: B/H sign-extended, BU/HU zero-extended, W unchanged; load completion wb_we=1.
REQ-025 Store completion: wb_valid=1, wb_we=0, wb_data=0.
REQ-026 Timeout counter cleared on entry to WAIT, incremented per WAIT cycle; reaching RESP_TIMEOUT without response -> next cycle wb_valid=1, wb_we=0, bus_err=1, FSM->IDLE.
REQ-027 dmem_resp_valid outside REQ/WAIT SHALL be ignored (late responses dropped, no output change).
REQ-028 wb_valid, misaligned, bus_err are exactly one-cycle pulses; at most one operation in flight.

Reset
REQ-029 rst=1 at a clock edge: FSM->IDLE, counter=0, all outputs 0 except in_ready=1 in the following cycle; an in-flight request is abandoned without wb_valid.
REQ-030 rst has priority over every other event in the same cycle.

Verification
REQ-031 NONE, alu_out=0x1234_5678, rd_in=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x1234_5678, wb_rd=5.
REQ-032 STORE B, alu_out=0x103, rs2_data=0xAB, ready after 2 cycles -> dmem_addr=0x100, wstrb=4'b1000, wdata=0xABABABAB held stable; after resp wb_valid=1, wb_we=0.
REQ-033 LOAD B, alu_out=0x102, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; same with BU -> 0x0000_0080.
REQ-034 LOAD W, alu_out=0x102 -> no dmem_req_valid, next cycle wb_valid=1, misaligned=1, wb_we=0.
REQ-035 RESP_TIMEOUT=4, LOAD accepted, no response -> bus_err pulse after 4 WAIT cycles; later resp_valid ignored; in_ready=1.
REQ-036 rst asserted while in WAIT -> IDLE next cycle, no wb_valid, following resp_valid ignored.
